seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Scan driver for a 4-digit, common-anode, multiplexed seven-segment display, sitting directly downstream of `cpu`. It consumes the 16-bit `display_out` word and shows it as four hex digits. The input is latched only at frame boundaries, so a write from the CPU never tears a displayed frame. Digit slots are timed off the same `clk`/`clk_enable` pair the pipeline uses.

## Interface
- `REFRESH_DIV`, default 50000: enabled cycles per digit slot; must be ≥ 2.
- `GUARD`, default 16: enabled cycles at the start of each slot with all anodes off (anti-ghosting); must satisfy 0 ≤ GUARD < REFRESH_DIV.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `clk_enable` input 1: advance qualifier; same signal the pipeline stages use.
- `value_in` input 16: word to display; digit 0 (rightmost) = `[3:0]`.
- `blank_lz` input 1: 1 = blank leading-zero digits.
- `anodes` output 4: active-low digit selects; bit i = digit i.
- `segments` output 7: active-low, order {g,f,e,d,c,b,a}.
- `frame_tick` output 1: one-clk pulse after each shadow load.

## Operation
- State:
  - `div_cnt` counts 0..REFRESH_DIV-1.
  - `digit` is 2 bits and wraps 3→0.
  - `shadow` is 16 bits.
- Reset (`rst`=1 at a clk edge): `div_cnt`=0, `digit`=0, `shadow`=0, `anodes`=4'b1111, `segments`=7'b1111111, `frame_tick`=0. `rst` has priority over everything, including mid-slot and mid-frame.
- `clk_enable`=0: `div_cnt`, `digit` and `shadow` hold.
- `clk_enable`=1 and `div_cnt` < REFRESH_DIV-1: `div_cnt` increments.
- `clk_enable`=1 and `div_cnt` = REFRESH_DIV-1:
  - `div_cnt`←0 and `digit`←`digit`+1.
  - If `digit`=3: `shadow`←`value_in` (sampled this edge) and `frame_tick`←1.
- `frame_tick` is 0 on every other edge.
- `value_in` is ignored between frame boundaries; no other path loads `shadow`.
- Leading-zero blanking: digit i is blanked when `blank_lz`=1, i ≥ 1, and `shadow` nibbles i..3 are all zero. Digit 0 is never blanked.
- Output registers update every clk edge, regardless of `clk_enable`, from pre-edge state:
  - If `div_cnt` < GUARD or `digit` is blanked: `anodes`←4'b1111 and `segments`←7'b1111111.
  - Otherwise: `anodes`←~(1<<`digit`) and `segments`←hex(`shadow` nibble `digit`).
- Hex table, active-low:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- `blank_lz` is not latched; it takes effect on the next output update.
- At most one anode is low in any cycle.

## Timing
- Output latency: one clk from state to `anodes`/`segments`.
- With `clk_enable` toggling every clk, wall time per slot is 2·REFRESH_DIV clks. A frame is 4 slots.
- First frame after reset displays `shadow`=0, i.e. "0" on digit 0 and, with `blank_lz`=1, digits 1–3 dark.
- `value_in` → visible: up to one full frame plus 1 clk.
- `frame_tick` is high in the clk cycle immediately after the loading edge, never for 2 consecutive cycles.
- GUARD=0: no dark interval; the anode switches directly between digits.

## Test plan
Use REFRESH_DIV=4 and GUARD=1 unless noted.
- Reset: `rst`=1 for 3 clks with arbitrary inputs → `anodes`=1111, `segments`=1111111 and `frame_tick`=0 at each post-reset edge. Deassert `rst` with `blank_lz`=0 → digit 0 shows 1000000 with `anodes`=1110 once `div_cnt` ≥ 1.
- Display word: `value_in`=16'h12AF, `clk_enable`=1 constant, `blank_lz`=0 → `frame_tick` pulses once after 16 enabled edges. The next frame shows:
  - digit 0 0001110 with `anodes`=1110
  - digit 1 0001000 with `anodes`=1101
  - digit 2 0100100 with `anodes`=1011
  - digit 3 1111001 with `anodes`=0111
  - each for 3 cycles, separated by 1 dark cycle.
- Leading-zero blanking: `value_in`=16'h0030 with `blank_lz`=1 → `anodes` never 0111 or 1011; digit 1 shows 0110000 and digit 0 shows 1000000. Then `value_in`=0 → only `anodes`=1110 ever asserts. Then `blank_lz`=0 → all four digits show 1000000.
- Tear-free update: change `value_in` 16'h1111→16'h2222 during digit 2's slot → digits 2 and 3 still show 1111001 in that frame. 0100100 appears only after the next `frame_tick`.
- Hold and mid-operation reset: `clk_enable` low for 20 clks mid-slot → `anodes`/`segments` constant and no `frame_tick`. Then assert `rst` during digit 3's slot → next edge gives `anodes`=1111. After release, the display restarts at digit 0 showing 0 and `shadow` is not loaded from `value_in`.
- Guard interval: REFRESH_DIV=8, GUARD=3 → each slot has `anodes`=1111 for exactly 3 enabled cycles, then the digit is selected for 5 cycles. Never more than one anode is low, checked every cycle.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: scan driver for a 4-digit common-anode multiplexed seven-segment display.
// The displayed word is reloaded into a shadow register only at frame boundaries, so frames never tear.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       digit;
    logic [15:0]      shadow;

    logic             in_guard;
    logic             lz_from1;
    logic             lz_from2;
    logic             lz_from3;
    logic             digit_blank;
    logic [3:0]       nibble;
    logic [3:0]       anodes_nxt;
    logic [6:0]       segments_nxt;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // With no guard interval the anode switches straight from one digit to the next.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);
            assign in_guard = (div_cnt < GUARD_END);
        end
    endgenerate

    always_comb begin
        lz_from3    = (shadow[15:12] == 4'h0);
        lz_from2    = lz_from3 && (shadow[11:8] == 4'h0);
        lz_from1    = lz_from2 && (shadow[7:4] == 4'h0);
        digit_blank = 1'b0;
        case (digit)
            2'd1:    digit_blank = blank_lz && lz_from1;
            2'd2:    digit_blank = blank_lz && lz_from2;
            2'd3:    digit_blank = blank_lz && lz_from3;
            default: digit_blank = 1'b0;
        endcase
        nibble = shadow[{digit, 2'b00} +: 4];
        if (in_guard || digit_blank) begin
            anodes_nxt   = 4'b1111;
            segments_nxt = 7'b1111111;
        end else begin
            anodes_nxt   = ~(4'b0001 << digit);
            segments_nxt = hex7(nibble);
        end
    end

    // Scan state advances on enabled cycles; the output stage updates every clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            digit      <= 2'd0;
            shadow     <= 16'h0000;
            anodes     <= 4'b1111;
            segments   <= 7'b1111111;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (clk_enable) begin
                if (div_cnt == CNT_LAST) begin
                    div_cnt <= '0;
                    digit   <= digit + 2'd1;
                    if (digit == 2'd3) begin
                        shadow     <= value_in;
                        frame_tick <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            anodes   <= anodes_nxt;
            segments <= segments_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: scoreboard of expected anode/segment words per cycle.
// Instance u_dut uses REFRESH_DIV=4/GUARD=1, instance u_dut8 uses REFRESH_DIV=8/GUARD=3.
module tb_seven_seg_scan;

    logic        clk;
    logic        rst;
    logic        clk_enable;
    logic [15:0] value_in;
    logic        blank_lz;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        frame_tick;
    logic [3:0]  anodes8;
    logic [6:0]  segments8;
    logic        frame_tick8;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] sb[$];
    logic [10:0] exp;

    seven_seg_scan #(.REFRESH_DIV(4), .GUARD(1)) u_dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .value_in(value_in),
        .blank_lz(blank_lz), .anodes(anodes), .segments(segments), .frame_tick(frame_tick)
    );

    seven_seg_scan #(.REFRESH_DIV(8), .GUARD(3)) u_dut8 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .value_in(value_in),
        .blank_lz(blank_lz), .anodes(anodes8), .segments(segments8), .frame_tick(frame_tick8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // One displayed frame: per digit, `guard` dark cycles then `lit` cycles of the digit.
    function automatic void push_frame(input logic [15:0] w, input logic blz,
                                       input int guard, input int lit);
        logic [15:0] upper;
        logic [3:0]  sel;
        logic        blanked;
        for (int d = 0; d < 4; d++) begin
            upper   = w >> (4 * d);
            blanked = blz && (d >= 1) && (upper == 16'h0000);
            sel     = 4'b0001 << d;
            for (int g = 0; g < guard; g++) sb.push_back({4'b1111, 7'b1111111});
            for (int c = 0; c < lit; c++) begin
                if (blanked) sb.push_back({4'b1111, 7'b1111111});
                else         sb.push_back({~sel, glyph(upper[3:0])});
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_tick !== 1'b1 && n < budget);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: frame_tick still %b after %0d cycles, required 1", frame_tick, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            value_in   = 16'($urandom);
            blank_lz   = 1'($urandom_range(0, 1));
            clk_enable = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({anodes, segments, frame_tick} !== {4'b1111, 7'b1111111, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: got an=%b seg=%b tick=%b, required 1111 1111111 0",
                         anodes, segments, frame_tick);
            end
            checks++;
            if ({anodes8, segments8, frame_tick8} !== {4'b1111, 7'b1111111, 1'b0}) begin
                errors++;
                $display("FAIL reset_state8: got an=%b seg=%b tick=%b, required 1111 1111111 0",
                         anodes8, segments8, frame_tick8);
            end
        end
        rst = 1'b0; blank_lz = 1'b0; clk_enable = 1'b1; value_in = 16'h0000;
        sb.push_back({4'b1111, 7'b1111111});
        sb.push_back({4'b1110, 7'b1000000});
        repeat (2) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL reset_release: got an=%b seg=%b, required an=%b seg=%b",
                         anodes, segments, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_display();
        value_in = 16'h12AF;
        for (int e = 3; e <= 16; e++) begin
            step();
            checks++;
            if (frame_tick !== (e == 16)) begin
                errors++;
                $display("FAIL first_tick: edge %0d frame_tick=%b, required %b", e, frame_tick, (e == 16));
            end
        end
        push_frame(16'h12AF, 1'b0, 1, 3);
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL display_12AF: cycle %0d got an=%b seg=%b, required an=%b seg=%b",
                         k, anodes, segments, exp[10:7], exp[6:0]);
            end
            if (k == 1) begin
                checks++;
                if (frame_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL tick_width: frame_tick=%b on cycle after pulse, required 0", frame_tick);
                end
            end
        end
    endtask

    task automatic test_blank();
        bit bad_anode;
        value_in = 16'h0030; blank_lz = 1'b1;
        wait_tick(40);
        push_frame(16'h0030, 1'b1, 1, 3);
        bad_anode = 1'b0;
        repeat (16) begin
            step();
            exp = sb.pop_front();
            if (anodes == 4'b0111 || anodes == 4'b1011) bad_anode = 1'b1;
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL blank_0030: got an=%b seg=%b, required an=%b seg=%b",
                         anodes, segments, exp[10:7], exp[6:0]);
            end
        end
        checks++;
        if (bad_anode) begin
            errors++;
            $display("FAIL blank_anodes: digit 2 or 3 selected=1, required 0");
        end
        value_in = 16'h0000;
        wait_tick(40);
        push_frame(16'h0000, 1'b1, 1, 3);
        repeat (16) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL blank_0000: got an=%b seg=%b, required an=%b seg=%b",
                         anodes, segments, exp[10:7], exp[6:0]);
            end
        end
        blank_lz = 1'b0;
        push_frame(16'h0000, 1'b0, 1, 3);
        repeat (16) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL unblank_0000: got an=%b seg=%b, required an=%b seg=%b",
                         anodes, segments, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_tear_free();
        value_in = 16'h1111;
        wait_tick(40);
        push_frame(16'h1111, 1'b0, 1, 3);
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL tear_1111: cycle %0d got an=%b seg=%b, required an=%b seg=%b",
                         k, anodes, segments, exp[10:7], exp[6:0]);
            end
            if (k == 9) value_in = 16'h2222;
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tear_tick: frame_tick=%b at frame end, required 1", frame_tick);
        end
        push_frame(16'h2222, 1'b0, 1, 3);
        repeat (16) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL tear_2222: got an=%b seg=%b, required an=%b seg=%b",
                         anodes, segments, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_hold_and_reset();
        repeat (6) step();
        clk_enable = 1'b0;
        repeat (20) begin
            step();
            checks++;
            if ({anodes, segments, frame_tick} !== {4'b1101, 7'b0100100, 1'b0}) begin
                errors++;
                $display("FAIL hold: got an=%b seg=%b tick=%b, required 1101 0100100 0",
                         anodes, segments, frame_tick);
            end
        end
        clk_enable = 1'b1; value_in = 16'hBEEF;
        repeat (7) step();
        rst = 1'b1;
        step();
        checks++;
        if ({anodes, segments, frame_tick} !== {4'b1111, 7'b1111111, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got an=%b seg=%b tick=%b, required 1111 1111111 0",
                     anodes, segments, frame_tick);
        end
        rst = 1'b0;
        push_frame(16'h0000, 1'b0, 1, 3);
        push_frame(16'hBEEF, 1'b0, 1, 3);
        for (int k = 1; k <= 32; k++) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes, segments} !== exp) begin
                errors++;
                $display("FAIL after_reset: cycle %0d got an=%b seg=%b, required an=%b seg=%b",
                         k, anodes, segments, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_guard();
        rst = 1'b1;
        step();
        rst = 1'b0; value_in = 16'h4567; blank_lz = 1'b0; clk_enable = 1'b1;
        push_frame(16'h0000, 1'b0, 3, 5);
        push_frame(16'h4567, 1'b0, 3, 5);
        for (int k = 1; k <= 64; k++) begin
            step();
            exp = sb.pop_front();
            checks++;
            if ({anodes8, segments8} !== exp) begin
                errors++;
                $display("FAIL guard_slot: cycle %0d got an=%b seg=%b, required an=%b seg=%b",
                         k, anodes8, segments8, exp[10:7], exp[6:0]);
            end
            checks++;
            if ($countones(~anodes8) > 1) begin
                errors++;
                $display("FAIL one_anode: cycle %0d anodes=%b, required at most one low", k, anodes8);
            end
            if (k == 32) begin
                checks++;
                if (frame_tick8 !== 1'b1) begin
                    errors++;
                    $display("FAIL guard_tick: frame_tick=%b, required 1", frame_tick8);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; clk_enable = 1'b0; value_in = 16'h0000; blank_lz = 1'b0;
        test_reset();
        test_display();
        test_blank();
        test_tear_free();
        test_hold_and_reset();
        test_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
